// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_pkg                                                   |
// | Shared state encoding, priority-mode constants and helpers.       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int c_PRIO_FIXED = 0;
  localparam int c_PRIO_RR    = 1;

  // Index width that stays at least one bit for a single-port build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_prio_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_prio_pick                                             |
// | Combinational priority picker searching upward from a start index.|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mem_arbiter_prio_pick #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic [IDX_W-1:0]     winner,
  output logic                 valid
);

  int w_idx;

  // Walk the offsets from farthest to nearest so the nearest active port wins.
  always_comb begin
    winner = '0;
    valid  = |req;
    w_idx  = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_idx = (int'(start) + k) % NUM_PORTS;
      if (|(req & (NUM_PORTS'(1) << w_idx))) begin
        winner = IDX_W'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter                                                       |
// | N-port arbiter onto one ready-handshake memory bus with timeout.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req_i,
  input  logic [NUM_PORTS-1:0]          we_i,
  input  logic [NUM_PORTS*DATA_W/8-1:0] sel_i,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]             rdata_o,
  output logic [NUM_PORTS-1:0]          ack_o,
  output logic [NUM_PORTS-1:0]          err_o,
  output logic [NUM_PORTS-1:0]          stall_o,
  output logic                          mem_ce_o,
  output logic                          mem_we_o,
  output logic [DATA_W/8-1:0]           mem_sel_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic [DATA_W-1:0]             mem_data_o,
  input  logic [DATA_W-1:0]             mem_data_i,
  input  logic                          mem_ready_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_ptr;
  logic                  r_we;
  logic [SEL_W-1:0]      r_sel;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ce;
  logic [NUM_PORTS-1:0]  r_ack;
  logic [NUM_PORTS-1:0]  r_err;

  logic [IDX_W-1:0]      w_start;
  logic [IDX_W-1:0]      w_win;
  logic [IDX_W-1:0]      w_ptr_nxt;
  logic                  w_valid;
  logic                  w_we;
  logic [SEL_W-1:0]      w_sel;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic [NUM_PORTS-1:0]  w_onehot;

  assign w_start = (PRIO_MODE == c_PRIO_RR) ? r_ptr : '0;

  mem_arbiter_prio_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req    (req_i),
    .start  (w_start),
    .winner (w_win),
    .valid  (w_valid)
  );

  // Winner's fields extracted from the packed request buses.
  assign w_we      = |(we_i & (NUM_PORTS'(1) << w_win));
  assign w_sel     = SEL_W'(sel_i >> (int'(w_win) * SEL_W));
  assign w_addr    = ADDR_W'(addr_i >> (int'(w_win) * ADDR_W));
  assign w_wdata   = DATA_W'(wdata_i >> (int'(w_win) * DATA_W));
  assign w_ptr_nxt = (w_win == IDX_W'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
  assign w_onehot  = NUM_PORTS'(1) << r_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_ce    <= 1'b0;
      r_ack   <= '0;
      r_err   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_idx   <= w_win;
            r_we    <= w_we;
            r_sel   <= w_sel;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            r_ce    <= 1'b1;
            r_state <= ST_BUSY;
            if (PRIO_MODE == c_PRIO_RR) begin
              r_ptr <= w_ptr_nxt;
            end
          end
        end
        ST_BUSY: begin
          // Ready is checked first so it beats a coincident timeout.
          if (mem_ready_i) begin
            if (!r_we) begin
              r_rdata <= mem_data_i;
            end
            r_ce    <= 1'b0;
            r_ack   <= w_onehot;
            r_err   <= '0;
            r_state <= ST_RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            r_ce    <= 1'b0;
            r_ack   <= w_onehot;
            r_err   <= w_onehot;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_ack   <= '0;
          r_err   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata_o    = r_rdata;
  assign ack_o      = r_ack;
  assign err_o      = r_err;
  assign stall_o    = req_i & ~r_ack;
  assign mem_ce_o   = r_ce;
  assign mem_we_o   = r_we;
  assign mem_sel_o  = r_sel;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter                                                    |
// | Fixed-priority 2-port and round-robin 3-port arbiters vs a model. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  req  [2];
  logic [2:0]  we   [2];
  logic [3:0]  sel  [2][3];
  logic [31:0] addr [2][3];
  logic [31:0] wd   [2][3];
  logic        rdy  [2];
  logic [31:0] mdat [2];

  logic [1:0]  ack_a, err_a, stall_a;
  logic [2:0]  ack_b, err_b, stall_b;
  logic        ce_a, ce_b, mwe_a, mwe_b;
  logic [3:0]  msel_a, msel_b;
  logic [31:0] maddr_a, maddr_b, mdo_a, mdo_b, rdata_a, rdata_b;

  mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(0), .TIMEOUT(TO)) u_fix (
    .clk(clk), .rst(rst), .req_i(req[0][1:0]), .we_i(we[0][1:0]),
    .sel_i({sel[0][1], sel[0][0]}), .addr_i({addr[0][1], addr[0][0]}),
    .wdata_i({wd[0][1], wd[0][0]}), .rdata_o(rdata_a), .ack_o(ack_a), .err_o(err_a),
    .stall_o(stall_a), .mem_ce_o(ce_a), .mem_we_o(mwe_a), .mem_sel_o(msel_a),
    .mem_addr_o(maddr_a), .mem_data_o(mdo_a), .mem_data_i(mdat[0]), .mem_ready_i(rdy[0]));

  mem_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]),
    .sel_i({sel[1][2], sel[1][1], sel[1][0]}), .addr_i({addr[1][2], addr[1][1], addr[1][0]}),
    .wdata_i({wd[1][2], wd[1][1], wd[1][0]}), .rdata_o(rdata_b), .ack_o(ack_b), .err_o(err_b),
    .stall_o(stall_b), .mem_ce_o(ce_b), .mem_we_o(mwe_b), .mem_sel_o(msel_b),
    .mem_addr_o(maddr_b), .mem_data_o(mdo_b), .mem_data_i(mdat[1]), .mem_ready_i(rdy[1]));

  logic [2:0]  o_ack [2], o_err [2], o_stall [2];
  logic        o_ce [2], o_we [2];
  logic [3:0]  o_sel [2];
  logic [31:0] o_addr [2], o_do [2], o_rd [2];

  assign o_ack[0]   = {1'b0, ack_a};
  assign o_ack[1]   = ack_b;
  assign o_err[0]   = {1'b0, err_a};
  assign o_err[1]   = err_b;
  assign o_stall[0] = {1'b0, stall_a};
  assign o_stall[1] = stall_b;
  assign o_ce[0]    = ce_a;
  assign o_ce[1]    = ce_b;
  assign o_we[0]    = mwe_a;
  assign o_we[1]    = mwe_b;
  assign o_sel[0]   = msel_a;
  assign o_sel[1]   = msel_b;
  assign o_addr[0]  = maddr_a;
  assign o_addr[1]  = maddr_b;
  assign o_do[0]    = mdo_a;
  assign o_do[1]    = mdo_b;
  assign o_rd[0]    = rdata_a;
  assign o_rd[1]    = rdata_b;

  // Transaction-level reference: one access per arbitration, timed by wait count.
  int          m_np [2] = '{2, 3};
  bit          m_rr [2] = '{1'b0, 1'b1};
  int          m_ptr [2], m_start [2], m_ackc [2], m_port [2], m_w [2];
  bit          m_infl [2], m_errf [2];
  logic        m_we [2];
  logic [3:0]  m_sel [2];
  logic [31:0] m_addr [2], m_wd [2], m_rdata [2];

  int cyc;
  int n_cmp;
  int n_fail;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d cyc%0d: observed %h expected %h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_infl[d]  = 1'b0;
      m_ptr[d]   = 0;
      m_rdata[d] = '0;
    end
  endtask

  task automatic check_quiet(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ack"}, d, 32'(o_ack[d]), 32'd0);
      chk({tag, "_err"}, d, 32'(o_err[d]), 32'd0);
      chk({tag, "_ce"},  d, 32'(o_ce[d]),  32'd0);
      chk({tag, "_rd"},  d, o_rd[d], m_rdata[d]);
    end
  endtask

  task automatic step();
    for (int d = 0; d < 2; d++) begin
      bit         busy, ackc;
      logic [2:0] eack, eerr;
      int         np, win, idx;
      np = m_np[d];
      if (m_infl[d] && cyc > m_ackc[d]) m_infl[d] = 1'b0;
      busy = m_infl[d] && cyc > m_start[d] && cyc < m_ackc[d];
      ackc = m_infl[d] && cyc == m_ackc[d];
      eack = ackc ? 3'(1 << m_port[d]) : 3'b000;
      eerr = (ackc && m_errf[d]) ? eack : 3'b000;

      chk("ack",   d, 32'(o_ack[d]),   32'(eack));
      chk("err",   d, 32'(o_err[d]),   32'(eerr));
      chk("stall", d, 32'(o_stall[d]), 32'(req[d] & ~eack));
      chk("ce",    d, 32'(o_ce[d]),    32'(busy));
      chk("rdata", d, o_rd[d], m_rdata[d]);
      if (busy) begin
        chk("mem_we",   d, 32'(o_we[d]),  32'(m_we[d]));
        chk("mem_sel",  d, 32'(o_sel[d]), 32'(m_sel[d]));
        chk("mem_addr", d, o_addr[d], m_addr[d]);
        chk("mem_data", d, o_do[d],   m_wd[d]);
      end

      // Memory: ready after the planned wait, random noise outside the access.
      mdat[d] = $urandom;
      if (busy) begin
        rdy[d] = (m_w[d] <= TO) && (cyc == m_start[d] + 1 + m_w[d]);
        if (rdy[d] && !m_we[d]) m_rdata[d] = mdat[d];
      end else begin
        rdy[d] = 1'($urandom);
      end

      // Requesters hold until acked, then may issue a fresh request.
      for (int p = 0; p < np; p++) begin
        if (!req[d][p] || eack[p]) begin
          req[d][p]  = ($urandom_range(0, 2) != 0);
          we[d][p]   = 1'($urandom);
          sel[d][p]  = 4'($urandom);
          addr[d][p] = $urandom;
          wd[d][p]   = $urandom;
        end
      end

      if (!m_infl[d] && req[d] != 3'b000) begin
        win = -1;
        for (int k = 0; k < np; k++) begin
          idx = ((m_rr[d] ? m_ptr[d] : 0) + k) % np;
          if (win < 0 && req[d][idx]) win = idx;
        end
        m_port[d]  = win;
        m_we[d]    = we[d][win];
        m_sel[d]   = sel[d][win];
        m_addr[d]  = addr[d][win];
        m_wd[d]    = wd[d][win];
        m_start[d] = cyc;
        m_w[d]     = $urandom_range(0, 6);
        m_errf[d]  = (m_w[d] > TO);
        m_ackc[d]  = cyc + 2 + (m_errf[d] ? TO : m_w[d]);
        m_infl[d]  = 1'b1;
        if (m_rr[d]) m_ptr[d] = (win + 1) % np;
      end
    end
  endtask

  initial begin
    bit found;
    cyc    = 0;
    n_cmp  = 0;
    n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      req[d]  = '0;
      we[d]   = '0;
      rdy[d]  = 1'b0;
      mdat[d] = '0;
      for (int p = 0; p < 3; p++) begin
        sel[d][p]  = '0;
        addr[d][p] = '0;
        wd[d][p]   = '0;
      end
    end
    model_reset();

    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_we",    d, 32'(o_we[d]),    32'd0);
      chk("rst_sel",   d, 32'(o_sel[d]),   32'd0);
      chk("rst_addr",  d, o_addr[d], 32'd0);
      chk("rst_data",  d, o_do[d],   32'd0);
      chk("rst_stall", d, 32'(o_stall[d]), 32'd0);
    end
    check_quiet("rst");
    rst = 1'b1;
    step();

    repeat (1500) begin
      tick();
      step();
    end

    // Pull reset asynchronously while the fixed-priority port is mid-access.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      step();
      if (m_infl[0] && cyc > m_start[0] && cyc < m_ackc[0]) found = 1'b1;
    end
    chk("rst_window", 0, 32'(found), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_quiet("async_rst");
    tick();
    check_quiet("in_rst");
    rst = 1'b1;
    step();

    repeat (1500) begin
      tick();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised shared-memory arbiter that sits between the pipeline's instruction-fetch and load/store ports and a single SRAM-style memory bus with a ready handshake. It generalises the core's fixed, zero-wait ROM/RAM split to NUM_PORTS requesters, selectable fixed or round-robin priority, variable memory wait states and a timeout. Per-port stall outputs feed the pipeline stall controller.

## Interface
- NUM_PORTS, 2: requester count, 1..8; port 0 is the data (load/store) port.
- ADDR_W, 32: address width.
- DATA_W, 32: data width, multiple of 8; SEL_W = DATA_W/8.
- PRIO_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 255: maximum BUSY cycles waiting for mem_ready_i, 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_PORTS  access request per port, held until ack.
- we_i  in  NUM_PORTS  1 = write.
- sel_i  in  NUM_PORTS*SEL_W  byte enables, port i at [i*SEL_W +: SEL_W].
- addr_i  in  NUM_PORTS*ADDR_W  addresses, packed likewise.
- wdata_i  in  NUM_PORTS*DATA_W  write data, packed likewise.
- rdata_o  out  DATA_W  read data, valid in the ack cycle.
- ack_o  out  NUM_PORTS  one-cycle completion pulse, one-hot.
- err_o  out  NUM_PORTS  timeout flag, valid with ack_o.
- stall_o  out  NUM_PORTS  req_i[i] & ~ack_o[i], combinational.
- mem_ce_o  out  1  memory chip enable.
- mem_we_o  out  1  memory write enable.
- mem_sel_o  out  SEL_W  byte enables.
- mem_addr_o  out  ADDR_W  address.
- mem_data_o  out  DATA_W  write data.
- mem_data_i  in  DATA_W  read data, valid when mem_ready_i is high.
- mem_ready_i  in  1  access complete.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req_i is high and no ack_o is asserted this cycle, pick a winner, register its index, we, sel, addr and wdata, and go to BUSY. Otherwise stay.
- BUSY: mem_ce_o = 1; mem_we_o, mem_sel_o, mem_addr_o and mem_data_o are driven from the registered copy, stable for the whole state. On mem_ready_i, capture mem_data_i (reads only; writes leave rdata unchanged), then go to RESP. If the wait counter reaches TIMEOUT without ready, set err and go to RESP.
- RESP: ack_o[winner] = 1 for exactly one cycle and err_o[winner] = err; then go to IDLE. mem_ce_o = 0.
- Fixed priority: lowest-index active req wins.
- Round-robin: search begins at pointer ptr, wrapping modulo NUM_PORTS. After each grant, ptr = winner+1, and ptr wraps from NUM_PORTS-1 to 0.
- The requester must hold req_i and its fields stable until ack_o. If req_i drops mid-transaction, the transaction still completes and the ack still pulses, and is ignored.
- Requests arriving in BUSY or RESP wait; stall_o stays high for them.
- NUM_PORTS = 1: the arbitration logic degenerates; grant always goes to port 0.

## Timing
- Reset (rst low, asynchronous): state IDLE; ptr = 0; wait counter, err and all outputs except stall_o are 0; rdata_o = 0. Any in-flight access is abandoned with no ack.
- Latency for a req seen in IDLE at cycle T with ready after W wait cycles: BUSY covers T+1..T+1+W, ack occurs at T+2+W. Zero-wait latency is 2 cycles.
- Best throughput is one access per 3 cycles. The mandatory IDLE cycle after RESP gives the next winner a new arbitration.
- Timeout: err is raised when the counter equals TIMEOUT, i.e. after TIMEOUT BUSY cycles. ack follows one cycle later with err_o = 1, and rdata_o is unchanged.
- mem_ready_i is ignored outside BUSY.
- Simultaneous ready and timeout in the same cycle: ready wins, and err = 0.

## Structure
- NUM_PORTS-independent state encodings (IDLE/BUSY/RESP) and the PRIO_* mode constants go in defines.v.
- One sub-module, prio_pick: a combinational NUM_PORTS-wide priority picker taking req and start pointer, producing a winner index and a valid flag. Fixed mode passes pointer 0.
- The top contains the FSM, the field registers, the wait counter of width clog2(TIMEOUT+1), and ptr.

## Test plan
- Single read, zero-wait: port 1 reads addr 0x100, memory returns 0xDEADBEEF with ready in the first BUSY cycle -> ack_o = 2'b10 two cycles after req, rdata_o = 0xDEADBEEF, stall_o[1] high until ack.
- Fixed-priority conflict: ports 0 and 1 request in the same cycle -> port 0 is acked first; port 1 is granted in the next IDLE and acked 3 cycles later; stall_o[1] stays high throughout.
- Round-robin with NUM_PORTS = 3, all requesting continuously -> grant order 0,1,2,0, each ack 3 cycles apart.
- Write with 3 wait states: port 0 writes 0x55AA to 0x40 with sel 4'b0011 -> mem_ce_o high for 4 cycles with stable fields; ack arrives 5 cycles after req; rdata_o unchanged.
- Timeout with TIMEOUT = 4 and ready never asserted -> ack_o[0] and err_o[0] rise together 6 cycles after req; the next request is serviced normally.
- Reset mid-BUSY: rst pulled low during BUSY -> mem_ce_o falls immediately, no ack is generated; after release, state is IDLE and ptr = 0.
